// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the sequential 16-bit shift-and-add multiplier.
package mul16_seq_pkg;

    localparam int WIDTH      = 16;
    localparam int ITERATIONS = 16;

    // Counter value during the final RUN iteration.
    localparam logic [3:0] LAST_COUNT = 4'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/add16.sv
// 16-bit adder; carry out of bit 15 is dropped.
module add16
    import mul16_seq_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned multiplier, product kept modulo 2^16.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | waiting for operands, in_ready high
//   ST_RUN  | 16 shift-and-add iterations, busy high
//   ST_DONE | product presented with out_valid until out_ready
module mul16_seq
    import mul16_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum;
    logic [3:0]       count;

    // Single adder shared by every iteration: acc + mcand.
    add16 u_add16 (
        .a   (acc),
        .b   (mcand),
        .sum (sum)
    );

    // acc only changes in RUN and is cleared on accept, so in DONE it holds the result.
    assign product = acc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status outputs, decoded from the registered state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (count == LAST_COUNT) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture and one shift-and-add step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (state == ST_IDLE && in_valid) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (state == ST_RUN) begin
            if (mplier[0]) begin
                acc <= sum;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 4'd1;
        end
    end

endmodule

// File: tb/tb_mul16_seq.sv
// Bench for mul16_seq: queue-based reference of expected products plus directed literals.
module tb_mul16_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] product;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_results = 0;
    logic [15:0] exp_q[$];
    logic        rand_stall = 1'b0;

    always #5 clk = ~clk;

    mul16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: expected product is the low half of the true product.
    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] full;
        full = 32'(x) * 32'(y);
        return full[15:0];
    endfunction

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_decode", {31'd0, in_ready}, {31'd0, !busy && !out_valid});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {16'd0, product}, 32'hFFFF_FFFF);
                end else begin
                    check("product", {16'd0, product}, {16'd0, exp_q[0]});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_results++;
                    end
                end
            end
        end
    end

    // Random backpressure, changed well away from both clock edges.
    always @(posedge clk) begin
        if (rand_stall) begin
            #2 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Waits for in_ready, presents operands for one accepting edge; returns at E0+1.
    task automatic send(input logic [15:0] x, input logic [15:0] y);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            a = x;
            b = y;
            in_valid = 1'b1;
            @(posedge clk);
            exp_q.push_back(ref_mul(x, y));
            #1;
            in_valid = 1'b0;
            a = $urandom();
            b = $urandom();
        end
    endtask

    // Directed vector with literal expectation and latency/II checks (out_ready high).
    task automatic run_lit(input string name, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] want);
        send(x, y);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k == 5)  check({name, "_busy"}, {31'd0, busy}, 32'd1);
            if (k == 15) check({name, "_early"}, {31'd0, out_valid}, 32'd0);
            if (k == 16) begin
                check({name, "_latency"}, {31'd0, out_valid}, 32'd1);
                check({name, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
                check({name, "_lit"}, {16'd0, product}, {16'd0, want});
            end
            if (k == 17) begin
                check({name, "_idle_after"}, {31'd0, in_ready}, 32'd1);
                check({name, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
            end
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_results;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_lit("p3x5", 16'h0003, 16'h0005, 16'h000F);
        run_lit("pffff", 16'hFFFF, 16'hFFFF, 16'h0001);
        run_lit("p100", 16'h0100, 16'h0100, 16'h0000);
        run_lit("pbzero", 16'h1234, 16'h0000, 16'h0000);
        run_lit("pazero", 16'h0000, 16'hBEEF, 16'h0000);

        // Stall in DONE, with ignored operand pulses.
        out_ready = 1'b0;
        send(16'd7, 16'd9);
        repeat (16) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            #1;
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_hold", {16'd0, product}, 32'h0000_003F);
            a = 16'h0055;
            b = 16'h0011;
            in_valid = (k % 2) == 0;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("stall_drain");

        // Reset during RUN iteration 8.
        send(16'h00C8, 16'h0190);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_product", {16'd0, product}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_lit("p2x3", 16'h0002, 16'h0003, 16'h0006);

        // Random pairs with random backpressure.
        start_results = n_results;
        rand_stall = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(16'($urandom()), 16'($urandom()));
        end
        drain("random_drain");
        rand_stall = 1'b0;
        #3;
        out_ready = 1'b1;
        check("random_count", n_results - start_results, 32'd200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
